// File: rtl/tx_slot_writer.sv
// TX record ingest: validates records from a 16-bit valid/ready stream, writes them into the
// frame slot ring, and publishes mem_wr_ptr only once a whole record has landed.
module tx_slot_writer #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] MIN_LEN = 16'd60,
  parameter logic [15:0] MAX_LEN = 16'd1514
) (
  input  logic              gmii_tx_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [ADDR_W-1:0] slot_wr_addr,
  output logic [15:0]       slot_wr_data,
  output logic [1:0]        slot_wr_byte_en,
  output logic              slot_wr_en,
  input  logic [ADDR_W-1:0] mem_rd_ptr,
  output logic [ADDR_W-1:0] mem_wr_ptr,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
);

  typedef enum logic [2:0] {IDLE, SPACE, HDR, DATA, DROP} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [1:0]        r_wr_be;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_mem_wr_ptr;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;
  logic [15:0]       r_len;
  logic [15:0]       r_n;
  logic [15:0]       r_idx;
  logic              r_commit;

  logic              w_acc;
  logic              w_busy;
  logic              w_len_ok;
  logic [15:0]       w_len_n;
  logic [ADDR_W-1:0] w_free;
  logic              w_fit;
  logic              w_last;

  assign w_acc    = in_valid & r_in_ready;
  assign w_busy   = (r_state == HDR) || (r_state == DATA);
  assign w_len_ok = (in_data >= MIN_LEN) && (in_data <= MAX_LEN);
  assign w_len_n  = 16'd7 + {1'b0, in_data[15:1]} + {15'd0, in_data[0]};
  // One slot stays empty so a full ring is distinguishable from an empty one.
  assign w_free   = mem_rd_ptr - r_mem_wr_ptr - ADDR_W'(1);
  assign w_fit    = 32'(w_free) >= 32'(r_n);
  assign w_last   = (r_idx == r_n - 16'd1);

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_be      <= 2'b00;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wp         <= '0;
      r_mem_wr_ptr <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_len        <= '0;
      r_n          <= '0;
      r_idx        <= '0;
      r_commit     <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_be    <= 2'b00;
      r_commit   <= 1'b0;
      // Publish one cycle after the final write, so the pointer never leads the data.
      if (r_commit) begin
        r_mem_wr_ptr <= r_wp;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
      end
      if (w_acc && in_sop) begin
        r_len <= in_data;
        r_n   <= w_len_n;
        if (w_busy) r_wp <= r_mem_wr_ptr;
        r_drop_cnt <= r_drop_cnt + 16'(w_busy) + 16'(!w_len_ok);
        if (w_len_ok) begin
          r_state    <= SPACE;
          r_in_ready <= 1'b0;
        end else begin
          r_state <= in_eop ? IDLE : DROP;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          SPACE: begin
            if (w_fit) begin
              r_wr_en   <= 1'b1;
              r_wr_be   <= 2'b11;
              r_wr_addr <= r_wp;
              r_wr_data <= r_len;
              r_wp      <= r_wp + ADDR_W'(1);
              r_idx     <= 16'd1;
              r_state   <= HDR;
            end else begin
              r_in_ready <= 1'b0;
            end
          end
          HDR, DATA: begin
            if (w_acc) begin
              if (w_last && in_eop) begin
                r_wr_en   <= 1'b1;
                r_wr_be   <= 2'b11;
                r_wr_addr <= r_wp;
                r_wr_data <= in_data;
                r_wp      <= r_wp + ADDR_W'(1);
                r_commit  <= 1'b1;
                r_state   <= IDLE;
              end else if (w_last || in_eop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
                r_wp       <= r_mem_wr_ptr;
                r_state    <= in_eop ? IDLE : DROP;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_be   <= 2'b11;
                r_wr_addr <= r_wp;
                r_wr_data <= in_data;
                r_wp      <= r_wp + ADDR_W'(1);
                r_idx     <= r_idx + 16'd1;
                if (r_idx == 16'd6) r_state <= DATA;
              end
            end
          end
          DROP: if (w_acc && in_eop) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign slot_wr_en      = r_wr_en;
  assign slot_wr_byte_en = r_wr_be;
  assign slot_wr_addr    = r_wr_addr;
  assign slot_wr_data    = r_wr_data;
  assign mem_wr_ptr      = r_mem_wr_ptr;
  assign frame_count     = r_frame_cnt;
  assign drop_count      = r_drop_cnt;

endmodule

// File: doc/tx_slot_writer.md
Name: tx_slot_writer

Overview:
- Upstream neighbour of the GMII frame sender. Accepts TX records as a 16-bit valid/ready word stream and writes them into the TX frame slot ring (16-bit words, 2^ADDR_W deep).
- Publishes mem_wr_ptr only after a whole record is written, so the sender never sees a partial record.
- Validates frame length and record framing, checks ring free space against the sender's mem_rd_ptr, and discards malformed records.

Parameters:
ADDR_W, 14, ring address width; must match the sender's pointer width.
MIN_LEN, 16'd60, minimum accepted frame_len in bytes (excluding FCS).
MAX_LEN, 16'd1514, maximum accepted frame_len in bytes (excluding FCS).

Ports:
gmii_tx_clk  in  1  single clock, shared with the sender
sys_rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_data  in  16  record word
in_sop  in  1  first word of record (word0)
in_eop  in  1  last word of record
in_ready  out  1  word accepted when in_valid & in_ready
slot_wr_addr  out  ADDR_W  ring write address
slot_wr_data  out  16  ring write data
slot_wr_byte_en  out  2  always 2'b11 when writing
slot_wr_en  out  1  ring write strobe
mem_rd_ptr  in  ADDR_W  sender's committed read pointer
mem_wr_ptr  out  ADDR_W  committed write pointer
frame_count  out  16  records committed, wraps
drop_count  out  16  records discarded, wraps

Behaviour:
- Record format:
  - w0 frame_len[15:0]
  - w1..w4 timestamp[63:0], MSW first
  - w5..w6 hash[31:0], MSW first
  - then D = ceil(frame_len/2) data words, first byte in [15:8]; for odd frame_len, [7:0] of the last word is pad.
  - Total N = 7 + D words. sop is on w0, eop on word N-1.
- Reset values: in_ready=0, slot_wr_en=0, slot_wr_addr=0, slot_wr_data=0, slot_wr_byte_en=0, mem_wr_ptr=0, frame_count=0, drop_count=0, state IDLE, working pointer wp=0.
- Ring arithmetic: modulo 2^ADDR_W. free = mem_rd_ptr - mem_wr_ptr - 1; one slot is always kept empty.
- States:
  - IDLE:
    - in_ready=1.
    - Accepted word without sop: discard silently.
    - Accepted word with sop: latch len=in_data and compute N.
      - If len<MIN_LEN or len>MAX_LEN: drop_count+1; if in_eop, stay IDLE, else go DROP.
      - Else go SPACE.
  - SPACE:
    - in_ready=0.
    - Each cycle, compare free >= N using the current mem_rd_ptr. When true, write w0 at wp (slot_wr_en=1 next cycle, addr=wp), wp+1, go HDR.
    - Waits indefinitely; no timeout.
  - HDR, then DATA:
    - in_ready=1. Each accepted word is written registered: slot_wr_en/addr/data are valid the cycle after acceptance, then wp+1.
    - A word counter tracks the index within the record.
    - Index 6 accepted moves HDR to DATA.
    - Word N-1 accepted with eop: mem_wr_ptr <= wp+1 (the pointer after the last word) one cycle after the final write, frame_count+1, go IDLE. Commit latency from last accept to mem_wr_ptr update is 2 cycles.
  - Abort rules in HDR/DATA, each incrementing drop_count by 1 and setting wp <= mem_wr_ptr (rollback; written words are orphaned, not published):
    - eop before index N-1: go IDLE.
    - Index N-1 without eop: go DROP.
    - sop on any word after w0: abort, then process the word as a new w0 in the same cycle (length check, then SPACE/DROP).
  - DROP: in_ready=1, discard words until an accepted eop, then IDLE. sop in DROP is treated as a new w0, as in IDLE.
- Space guarantee: the block never writes beyond N words past mem_wr_ptr, so the sender's unread data is never overwritten.
- Boundaries:
  - Write across address 2^ADDR_W-1 wraps to 0.
  - Exact-fit free==N is accepted.
  - mem_rd_ptr advancing during SPACE is seen in the following cycle.
- Counters wrap at 16 bits.
- sys_rst mid-record: immediate return to reset values; the partial record is lost. The sender is reset by the same sys_rst.

Test Plan:
- Single 60-byte record, ring empty -> 37 writes at addr 0..36, data matching input; mem_wr_ptr 0->37 two cycles after eop accept; frame_count=1.
- Odd length 61, wp starting at 16370 -> 38 writes, addresses wrap 16383->0, mem_wr_ptr=24 (mod 16384); pad byte written as supplied.
- frame_len=59 and frame_len=1515 with sop, 10 more words, eop -> no slot_wr_en, drop_count=2, mem_wr_ptr unchanged; next valid record commits normally.
- Early eop at data word 5 of a 100-byte record -> drop_count+1, mem_wr_ptr unchanged, wp rolled back; next record overwrites the same addresses.
- Ring with free=30, 60-byte record (N=37) -> in_ready held 0 in SPACE; raise mem_rd_ptr by 7 -> free=37, record proceeds and commits.
- sop at index 4 of a record -> first record dropped (drop_count+1), new record started from that word, commits with frame_count+1; sys_rst mid-DATA -> all outputs return to reset values next cycle.
